// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, extended immediate out.
// master = instruction source / result sink, slave = the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 64,
    parameter int ERRW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [ERRW-1:0] err_cnt;

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal, err_cnt
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, imm, fmt, illegal, err_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator behind a 2-entry skid buffer.
// Optional IMMGEN_CSR_ZIMM_EN: CSR immediate forms (inst[14]=1) yield fmt 6 / zimm.
//   state    | meaning
//   ST_EMPTY | no result held
//   ST_ONE   | OUT holds a result, SKID empty
//   ST_FULL  | OUT and SKID both hold results, in_ready low
module imm_gen_pipe #(
    parameter int XLEN = 64,
    parameter int ERRW = 8
) (
    input logic         clk,
    input logic         reset,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_out_imm, r_skid_imm;
    logic [2:0]      r_out_fmt, r_skid_fmt;
    logic [ERRW-1:0] r_err_cnt;

    logic [31:0]     w_inst;
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_accept, w_consume;
    logic            w_load_out_new, w_load_out_skid, w_load_skid;
    logic            w_unused_funct3;

    assign w_inst          = bus.instruction;
    assign w_unused_funct3 = ^w_inst[14:12];

    always_comb begin
        w_fmt   = 3'd7;
        w_imm32 = '0;
        case (w_inst[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                w_fmt   = 3'd1;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            7'b1110011: begin
`ifdef IMMGEN_CSR_ZIMM_EN
                if (w_inst[14]) begin
                    w_fmt   = 3'd6;
                    w_imm32 = {27'b0, w_inst[19:15]};
                end else begin
                    w_fmt   = 3'd1;
                    w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
                end
`else
                w_fmt   = 3'd1;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
`endif
            end
            7'b0100011: begin
                w_fmt   = 3'd2;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            7'b1100011: begin
                w_fmt   = 3'd3;
                w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = 3'd4;
                w_imm32 = {w_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt   = 3'd5;
                w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                w_fmt   = 3'd0;
                w_imm32 = '0;
            end
            default: begin
                w_fmt   = 3'd7;
                w_imm32 = '0;
            end
        endcase
    end

    // Every format is already correct as a signed 32-bit value; widen from bit 31.
    assign w_imm = XLEN'($signed(w_imm32));

    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.imm       = r_out_imm;
    assign bus.fmt       = r_out_fmt;
    assign bus.illegal   = (r_out_fmt == 3'd7);
    assign bus.err_cnt   = r_err_cnt;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_consume = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_out_new = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_out_new = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_load_out_skid = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_imm  <= '0;
            r_out_fmt  <= '0;
            r_skid_imm <= '0;
            r_skid_fmt <= '0;
        end else begin
            if (w_load_out_new) begin
                r_out_imm <= w_imm;
                r_out_fmt <= w_fmt;
            end else if (w_load_out_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_fmt <= r_skid_fmt;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
            end
        end
    end

    // Counted on acceptance so a stalled output does not hide a bad opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_accept && (w_fmt == 3'd7) && (r_err_cnt != {ERRW{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: random instructions against an arithmetic
// reference model, plus directed buffer, reset and saturation scenarios.
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .ERRW(8)) bus ();
    imm_gen_pipe #(.XLEN(64), .ERRW(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    imm_gen_pipe_if #(.XLEN(32), .ERRW(2)) bus2 ();
    imm_gen_pipe #(.XLEN(32), .ERRW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];
    int   model_err = 0;
    bit   rand_rdy  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic longint wrap(input longint v, input longint span);
        return (v >= span / 2) ? v - span : v;
    endfunction

    function automatic res_t model(input logic [31:0] inst);
        res_t   r;
        longint v;
        int     f;
        v = 0;
        f = 7;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                f = 1;
                v = wrap(longint'(inst[31:20]), 4096);
`ifdef IMMGEN_CSR_ZIMM_EN
                if (inst[6:0] == 7'b1110011 && inst[14]) begin
                    f = 6;
                    v = longint'(inst[19:15]);
                end
`endif
            end
            7'b0100011: begin
                f = 2;
                v = wrap(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 4096);
            end
            7'b1100011: begin
                f = 3;
                v = wrap(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                         longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 8192);
            end
            7'b0110111, 7'b0010111: begin
                f = 4;
                v = wrap(longint'(inst[31:12]) * 4096, 64'sd4294967296);
            end
            7'b1101111: begin
                f = 5;
                v = wrap(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                         longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 2097152);
            end
            7'b0110011, 7'b0111011: f = 0;
            default: f = 7;
        endcase
        r.imm = v;
        r.fmt = f[2:0];
        return r;
    endfunction

    // Monitor: pop on each output handshake, push on each input handshake.
    always @(negedge clk) begin
        if (!reset) begin
            res_t e;
            check("err_cnt", 64'(bus.err_cnt), 64'(model_err));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got imm %h fmt %0d, expected nothing", bus.imm, bus.fmt);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_imm", bus.imm, e.imm);
                    check("sb_fmt", 64'(bus.fmt), 64'(e.fmt));
                    check("sb_illegal", 64'(bus.illegal), 64'(e.fmt == 3'd7));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.instruction);
                exp_q.push_back(e);
                if (e.fmt == 3'd7 && model_err < 255) model_err++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] inst);
        int t;
        t = 0;
        bus.in_valid    = 1'b1;
        bus.instruction = inst;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        res_t r;
        int   err_before;
        logic [31:0] inst;
        logic [6:0]  ops[12];
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011};

        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.instruction  = '0;
        bus.out_ready    = 1'b0;
        bus2.in_valid    = 1'b0;
        bus2.instruction = '0;
        bus2.out_ready   = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_imm", bus.imm, 64'd0);
        check("rst_fmt", 64'(bus.fmt), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send(32'hFFF00093);
        check("addi_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", 64'(bus.fmt), 64'd1);

        send(32'hFE000EE3);
        check("beq_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_fmt", 64'(bus.fmt), 64'd3);
        send(32'h800000B7);
        check("lui_imm", bus.imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_fmt", 64'(bus.fmt), 64'd4);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        send(32'h00500093);
        send(32'h00112623);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h0080006F;
        r = model(32'h00500093);
        repeat (2) begin
            @(negedge clk);
            check("held_in_ready", 64'(bus.in_ready), 64'd0);
            check("held_out_valid", 64'(bus.out_valid), 64'd1);
            check("held_imm", bus.imm, r.imm);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'h0080006F);
        drain();

        err_before = model_err;
        send(32'h0000_0000);
        check("ill_fmt", 64'(bus.fmt), 64'd7);
        check("ill_flag", 64'(bus.illegal), 64'd1);
        check("ill_imm", bus.imm, 64'd0);
        send(32'h0000_0000);
        check("ill2_fmt", 64'(bus.fmt), 64'd7);
        check("ill_err_cnt", 64'(bus.err_cnt), 64'(err_before + 2));

        send(32'h3002D073);
`ifdef IMMGEN_CSR_ZIMM_EN
        check("csr_fmt", 64'(bus.fmt), 64'd6);
        check("csr_imm", bus.imm, 64'd5);
`else
        check("csr_fmt", 64'(bus.fmt), 64'd1);
        check("csr_imm", bus.imm, 64'h300);
`endif
        drain();

        bus.out_ready = 1'b0;
        send(32'h0000_0000);
        send(32'h0010_0093);
        check("pre_rst_full", 64'(bus.in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_imm", bus.imm, 64'd0);
        check("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        model_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_output", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) inst = $urandom();
            else inst = ($urandom() & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 11)]);
            send(inst);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        drain();

        bus2.instruction = 32'h800000B7;
        bus2.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check("x32_lui_imm", 64'(bus2.imm), 64'h8000_0000);
        check("x32_lui_fmt", 64'(bus2.fmt), 64'd4);
        bus2.instruction = 32'h0000_0000;
        bus2.in_valid    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check("x32_err_sat", 64'(bus2.err_cnt), 64'd3);
        check("x32_illegal", 64'(bus2.illegal), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the RISC-V datapath. Replaces the bit-31-only extender: decodes the instruction format from the opcode, assembles the I/S/B/U/J immediate, and sign-extends it to XLEN. A 2-entry skid buffer with valid/ready handshakes on both sides allows back-to-back throughput with one cycle of latency. A saturating counter tracks undecodable opcodes for debug.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- ERRW, 8, width of the illegal-opcode counter.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction this cycle.
- instruction  input  32  instruction word.
- out_valid  output  1  imm/fmt/illegal hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- imm  output  XLEN  extended immediate.
- fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal.
- illegal  output  1  high when fmt==7.
- err_cnt  output  ERRW  count of accepted illegal instructions, saturating.

## Operation
- Opcode decode (inst[6:0]):
  - I: 0000011, 0010011, 0011011, 1100111, 1110011.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011, 0111011 (imm=0).
  - Anything else: illegal (imm=0).
- Immediate assembly, then sign-extension of the top bit to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, extended from bit 31.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Buffer: output register (OUT) plus skid register (SKID).
  - States: EMPTY (neither valid), ONE (OUT only), FULL (both).
  - in_ready = !SKID.valid, registered.
  - Accept (in_valid && in_ready) while OUT is empty or being consumed (out_valid && out_ready), with SKID empty: the result loads OUT.
  - Accept while OUT is held (out_valid && !out_ready): the result loads SKID, giving FULL.
  - In FULL, a consume moves SKID to OUT and SKID empties.
  - Order is strictly preserved. No result is dropped or duplicated.
- err_cnt increments by 1 on each accepted illegal instruction and saturates at 2^ERRW-1. It counts at acceptance, not at output.

## Timing
- Latency: an instruction accepted at edge N drives out_valid/imm/fmt after edge N (visible in cycle N+1) when OUT is free.
- Throughput: 1 per cycle while out_ready=1.
- out_valid stays high, and imm/fmt/illegal stay stable, until a cycle with out_ready=1.
- Simultaneous accept and consume in ONE: OUT is replaced, state stays ONE.
- Simultaneous accept and consume in FULL cannot occur, because in_ready=0 in FULL.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, imm=0, fmt=0, illegal=0, err_cnt=0.
  - SKID is emptied and in_ready=1.
  - Buffered entries are discarded.

## Configuration
- IMMGEN_CSR_ZIMM_EN
  - Defined: opcode 1110011 with inst[14]=1 gives fmt=6 and imm = zero-extended inst[19:15].
  - Undefined: every 1110011 instruction is plain I-type, with imm = sign-extended inst[31:20] and fmt=1.

## Test plan
- Reset asserted mid-stream with FULL buffer -> out_valid=0, imm=0, err_cnt=0, in_ready=1 immediately. No stale output after release.
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle imm=0xFFFFFFFFFFFFFFFF, fmt=1.
- 0xFE000EE3 (beq -4) then 0x800000B7 (lui 0x80000), back-to-back -> imm=0xFFFFFFFFFFFFFFFC fmt=3, then imm=0xFFFFFFFF80000000 fmt=4, on consecutive cycles.
- out_ready=0, present three instructions:
  - first two accepted; in_ready=0 after the second; third is held.
  - raise out_ready -> three results emerge in order, one per cycle.
- 0x00000000 presented twice -> fmt=7, illegal=1, imm=0 each time; err_cnt=2. With ERRW=2, five illegals -> err_cnt=3.
- 0x3002D073 (csrrwi x0,mstatus,5):
  - with IMMGEN_CSR_ZIMM_EN -> fmt=6, imm=5.
  - without it -> fmt=1, imm=0x300.
